byte_enable_register: RTL and testbench
=======================================

// Module: byte_enable_register
//
// PURPOSE
//   Single memory-mapped data register with per-byte write enables.
//   Sits behind the bus/register-file decoder: the decoder drives en when this
//   register is addressed, and be selects the lanes to update.
//   Stored value is continuously visible on q for readback and downstream logic.
//   A 16-bit (two-lane) instance is the standard configuration.
//
// PARAMETERS
//   WIDTH        16  data width in bits; must be a multiple of 8
//   RESET_VALUE  0   value loaded into q on reset (WIDTH bits)
//   Derived: NUM_BYTES = WIDTH/8 (not overridable)
//
// PORTS
//   clk    in   1          system clock; all updates on rising edge
//   reset  in   1          asynchronous, active-high reset
//   en     in   1          access (write) enable from the address decoder
//   be     in   NUM_BYTES  byte-lane enables; be[i] gates d[8i+7:8i]
//                          16-bit: be[1] = high byte, be[0] = low byte
//   d      in   WIDTH      write data
//   q      out  WIDTH      stored register contents (registered output)
//   One clock; reset is asynchronous and active-high.
//
// BEHAVIOUR
//   - Reset: while reset=1, q = RESET_VALUE (0x0000 by default).
//     - Takes effect immediately, without waiting for a clock edge.
//     - Overrides en/be/d; no write occurs on any edge while reset=1.
//   - Write: on rising clk with reset=0 and en=1, for each lane i:
//     - be[i]=1 -> q[8i+7:8i] <= d[8i+7:8i]
//     - be[i]=0 -> lane holds its previous value
//   - Hold cases (no clock edge updates q):
//     - en=0: q holds regardless of be and d.
//     - en=1, be=all-zero: q holds.
//   - Latency: one cycle; new lane value is visible on q right after the
//     capturing edge. No combinational path from d, en or be to q.
//   - X/undriven d while en=0: must not affect q.
//   - Reset released mid-stream: the first write occurs on the first rising
//     edge after reset deasserts with en=1.
//   - Handshake: none; every enabled edge is a completed write (no stall or ack).
//   - Lanes are fully independent; no read side-effects.
//
// TESTING
//   1. Reset: pulse reset high between clock edges -> q=0x0000 immediately,
//      before the next edge.
//   2. Disabled writes: en=0, be=2'b11, d=0xDEAD then 0xBEEF over several edges
//      -> q stays 0x0000.
//   3. Full write: en=1, be=2'b11
//      - d=0xDEAD -> q=0xDEAD
//      - then d=0xBEEF -> q=0xBEEF
//   4. Low lane only: from q=0xBEEF, be=2'b01
//      - d=0xFACE -> q=0xBECE
//      - then d=0xCAFE -> q=0xBEFE
//   5. High lane only: from q=0xBEFE, be=2'b10
//      - d=0xF00D -> q=0xF0FE
//      - then d=0xBEAD -> q=0xBEFE
//   6. Edge cases:
//      - en=1, be=2'b00, d=0x1234 -> q unchanged.
//      - assert reset mid-write with en=1 -> q=0x0000 at once and stays 0
//        until reset drops.

Source files
------------

// File: rtl/byte_enable_register.sv
// Single data register with per-byte write enables, written from a bus decoder.
// The stored value is continuously presented on q; lanes update independently.
module byte_enable_register #(
    parameter int               WIDTH       = 16,
    parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en,
    input  logic [WIDTH/8-1:0]   be,
    input  logic [WIDTH-1:0]     d,
    output logic [WIDTH-1:0]     q
);

    localparam int NUM_BYTES = WIDTH / 8;

    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] next_s;

    // Lane-wise next value: an unselected lane (or en=0) recirculates, so d is never observed.
    always_comb begin
        next_s = q_r;
        for (int i = 0; i < NUM_BYTES; i++) begin
            if (en && be[i]) begin
                next_s[8*i +: 8] = d[8*i +: 8];
            end else begin
                next_s[8*i +: 8] = q_r[8*i +: 8];
            end
        end
    end

    // Storage register; reset wins over any write on the same edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_r <= RESET_VALUE;
        end else begin
            q_r <= next_s;
        end
    end

    assign q = q_r;

endmodule

// File: tb/tb_byte_enable_register.sv
// Directed bench for byte_enable_register: stimulus pushes expected q values,
// an independent monitor pops and compares them against the live output.
module tb_byte_enable_register;

    logic        clk;
    logic        reset;
    logic        en;
    logic [1:0]  be;
    logic [15:0] d;
    logic [15:0] q;

    logic [15:0] exp_q[$];
    string       name_q[$];
    int          checks;
    int          errors;

    byte_enable_register #(
        .WIDTH       (16),
        .RESET_VALUE (16'h0000)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .be    (be),
        .d     (d),
        .q     (q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: whenever an expectation is queued, sample q shortly after and compare.
    initial begin
        logic [15:0] e;
        string       n;
        forever begin
            wait (exp_q.size() != 0);
            #1;
            e = exp_q.pop_front();
            n = name_q.pop_front();
            checks++;
            if (q !== e) begin
                errors++;
                $display("FAIL %s: q=0x%04h expected 0x%04h", n, q, e);
            end
        end
    end

    task automatic expect_q(input logic [15:0] value, input string name);
        exp_q.push_back(value);
        name_q.push_back(name);
    endtask

    // Apply inputs at the falling edge, let one rising edge capture, then queue the expectation.
    task automatic do_cycle(input logic e_in, input logic [1:0] be_in, input logic [15:0] d_in,
                            input logic [15:0] expected, input string name);
        @(negedge clk);
        en = e_in;
        be = be_in;
        d  = d_in;
        @(posedge clk);
        #2;
        expect_q(expected, name);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        en     = 1'b0;
        be     = 2'b00;
        d      = 16'h0000;

        #3;
        expect_q(16'h0000, "reset_value");
        @(negedge clk);
        reset = 1'b0;

        do_cycle(1'b0, 2'b11, 16'hDEAD, 16'h0000, "disabled_dead");
        do_cycle(1'b0, 2'b11, 16'hBEEF, 16'h0000, "disabled_beef");
        do_cycle(1'b0, 2'b11, 16'hxxxx, 16'h0000, "disabled_x_data");

        do_cycle(1'b1, 2'b11, 16'hDEAD, 16'hDEAD, "full_dead");
        do_cycle(1'b1, 2'b11, 16'hBEEF, 16'hBEEF, "full_beef");

        do_cycle(1'b1, 2'b01, 16'hFACE, 16'hBECE, "low_face");
        do_cycle(1'b1, 2'b01, 16'hCAFE, 16'hBEFE, "low_cafe");

        do_cycle(1'b1, 2'b10, 16'hF00D, 16'hF0FE, "high_f00d");
        do_cycle(1'b1, 2'b10, 16'hBEAD, 16'hBEFE, "high_bead");

        do_cycle(1'b1, 2'b00, 16'h1234, 16'hBEFE, "be_zero");
        do_cycle(1'b0, 2'b11, 16'hxxxx, 16'hBEFE, "disabled_x_hold");

        // Reset asserted between edges while a write is pending.
        @(negedge clk);
        en = 1'b1;
        be = 2'b11;
        d  = 16'h5555;
        #1;
        reset = 1'b1;
        #1;
        expect_q(16'h0000, "reset_async");
        @(posedge clk);
        #2;
        expect_q(16'h0000, "reset_over_write");
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #2;
        expect_q(16'h5555, "first_after_reset");

        do_cycle(1'b1, 2'b10, 16'hA0B0, 16'hA055, "high_after_reset");

        for (int i = 0; i < 100 && exp_q.size() != 0; i++) begin
            #1;
        end
        #2;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
